// File: rtl/prog_updown_counter.sv
// Programmable-step up/down counter with inclusive limit and wrap/saturate/one-shot overflow modes.
// Outputs are registered one edge after the sampled inputs, except at_limit, which is combinational.
module prog_updown_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_val,
  input  logic              load,
  input  logic              up_down,
  input  logic              count_en,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  out_val,
  output logic              carry_out,
  output logic              at_limit,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] MODE_SAT = 2'b01;
  localparam logic [1:0] MODE_OS  = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   step_x, cnt_x, lim_x, up_c, dn_c;
  logic             ovf, unf, oob, step_nz, is_os;
  logic [WIDTH-1:0] sat_nxt, wrap_nxt, ld_val, term;

  // One extra bit keeps both the overshoot above limit and the borrow below zero visible.
  assign step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign cnt_x   = {1'b0, cnt_q};
  assign lim_x   = {1'b0, limit};
  assign up_c    = cnt_x + step_x;
  assign dn_c    = cnt_x - step_x;
  assign ovf     = up_c > lim_x;
  assign unf     = dn_c[WIDTH];
  assign oob     = up_down ? ovf : unf;
  assign step_nz = |step;
  assign is_os   = (mode == MODE_OS);

  assign sat_nxt  = up_down ? (ovf ? limit : up_c[WIDTH-1:0])
                            : (unf ? '0    : dn_c[WIDTH-1:0]);
  assign wrap_nxt = up_down ? (ovf ? '0    : up_c[WIDTH-1:0])
                            : (unf ? limit : dn_c[WIDTH-1:0]);
  assign ld_val   = (in_val > limit) ? limit : in_val;
  assign term     = up_down ? limit : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    done_d  = 1'b0;
    if (load) begin
      cnt_d   = ld_val;
      state_d = is_os ? RUN : IDLE;
    end else if (!is_os) begin
      state_d = IDLE;
      if (count_en && step_nz) begin
        cnt_d   = (mode == MODE_SAT) ? sat_nxt : wrap_nxt;
        carry_d = oob;
      end
    end else if (state_q == RUN && count_en && step_nz) begin
      // A run sitting on its terminal ends without moving; otherwise it ends on reaching it.
      if (cnt_q == term) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d   = sat_nxt;
        carry_d = oob;
        if (sat_nxt == term) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign out_val   = cnt_q;
  assign carry_out = carry_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign at_limit  = (cnt_q == limit);

endmodule
